// File: rtl/cpu_ask2_sysid_pkg.sv
// rtl/cpu_ask2_sysid_pkg.sv - shared types and constants for the sysid checker
//
// Purpose: state encoding, sysid slave word addresses and the default
// expected image identification values, shared by the checker and its bench.
// Ports: none (package).

package cpu_ASK2_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ID_SETUP = 3'd1,
    ST_ID_CAP   = 3'd2,
    ST_TS_SETUP = 3'd3,
    ST_TS_CAP   = 3'd4,
    ST_EVAL     = 3'd5
  } sysid_state_t;

  // Word addresses inside the sysid slave
  localparam logic SID_ADDR_ID = 1'b0;
  localparam logic SID_ADDR_TS = 1'b1;

  // Values the host software was built against
  localparam logic [31:0] DEF_EXP_ID        = 32'd21;
  localparam logic [31:0] DEF_EXP_TIMESTAMP = 32'd1526990575;

  localparam int SETTLE_W = 4;
  localparam int RETRY_W  = 3;

endpackage

// File: rtl/cpu_ask2_sysid_checker.sv
// rtl/cpu_ask2_sysid_checker.sv - boot-time sysid read and compare sequencer
//
// Purpose: after reset (AUTO_START=1) or on a start pulse, reads the sysid ID
// word (address 0) and timestamp word (address 1), compares each against the
// build-time expected values and publishes latched results plus a pass flag.
// Optional feature macro: SYSID_CHECKER_RETRY_EN (re-run the check up to
// MAX_RETRY times after a mismatch before reporting).
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   single-cycle request for a new check (ignored while busy)
//   sid_address  out  word address to the sysid slave
//   sid_read     out  read strobe to the sysid slave
//   sid_readdata in   32-bit combinational read data from the sysid slave
//   busy         out  check in progress
//   done         out  one-cycle pulse when a result is published
//   match        out  last check passed both words
//   id_ok        out  ID word matched on last check
//   ts_ok        out  timestamp word matched on last check
//   id_value     out  ID word captured on last check
//   ts_value     out  timestamp word captured on last check
//   retry_cnt    out  retries used on last check

module cpu_ask2_sysid_checker
  import cpu_ASK2_sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID        = DEF_EXP_ID,
  parameter logic [31:0] EXP_TIMESTAMP = DEF_EXP_TIMESTAMP,
  parameter int          SETTLE_CYCLES = 1,
  parameter bit          AUTO_START    = 1'b1,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 sid_address,
  output logic                 sid_read,
  input  logic [31:0]          sid_readdata,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value,
  output logic [RETRY_W-1:0]   retry_cnt
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  sysid_state_t        state;
  sysid_state_t        state_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                settle_last;
  logic                auto_pend;
  logic                accept;
  logic                retry_go;

  assign settle_last = (settle_cnt == SETTLE_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and bus/status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    sid_address = SID_ADDR_ID;
    sid_read    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    accept      = 1'b0;
    retry_go    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start || auto_pend) begin
          accept     = 1'b1;
          state_next = ST_ID_SETUP;
        end
      end
      ST_ID_SETUP: begin
        sid_read = 1'b1;
        if (settle_last) begin
          state_next = ST_ID_CAP;
        end
      end
      ST_ID_CAP: begin
        sid_read   = 1'b1;
        state_next = ST_TS_SETUP;
      end
      ST_TS_SETUP: begin
        sid_address = SID_ADDR_TS;
        sid_read    = 1'b1;
        if (settle_last) begin
          state_next = ST_TS_CAP;
        end
      end
      ST_TS_CAP: begin
        sid_address = SID_ADDR_TS;
        sid_read    = 1'b1;
        state_next  = ST_EVAL;
      end
      ST_EVAL: begin
`ifdef SYSID_CHECKER_RETRY_EN
        if (!match && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
          retry_go   = 1'b1;
          state_next = ST_ID_SETUP;
        end else begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
`else
        done       = 1'b1;
        state_next = ST_IDLE;
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Settle counter: counts the cycles an address has been held; restarts at 0
  // on entry to each setup state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (((state == ST_ID_SETUP) || (state == ST_TS_SETUP)) && !settle_last) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  // One automatic check per reset release; it is consumed by the first accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pend <= AUTO_START;
    end else if (accept) begin
      auto_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture and compare. The timestamp compare uses the slave data directly in
  // TS_CAP so that results are already valid in the EVAL cycle, alongside done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value <= '0;
      ts_value <= '0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      match    <= 1'b0;
    end else begin
      if (state == ST_ID_CAP) begin
        id_value <= sid_readdata;
      end
      if (state == ST_TS_CAP) begin
        ts_value <= sid_readdata;
        id_ok    <= (id_value == EXP_ID);
        ts_ok    <= (sid_readdata == EXP_TIMESTAMP);
        match    <= (id_value == EXP_ID) && (sid_readdata == EXP_TIMESTAMP);
      end
    end
  end

`ifdef SYSID_CHECKER_RETRY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
    end else if (retry_go) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ask2_sysid_checker.sv
// tb/tb_cpu_ask2_sysid_checker.sv - scoreboard bench for cpu_ask2_sysid_checker

module tb_cpu_ask2_sysid_checker;
  import cpu_ASK2_sysid_pkg::*;

  typedef struct {
    int          cyc;
    logic        m;
    logic        io;
    logic        to;
    logic [31:0] iv;
    logic [31:0] tv;
    logic [2:0]  rc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic [31:0] id_data = DEF_EXP_ID;
  logic [31:0] ts_data = DEF_EXP_TIMESTAMP;

  logic        addr1, rd1, busy1, done1, match1, idok1, tsok1;
  logic [31:0] idv1, tsv1, rdata1;
  logic [2:0]  rc1;
  logic        addr2, rd2, busy2, done2, match2, idok2, tsok2;
  logic [31:0] idv2, tsv2, rdata2;
  logic [2:0]  rc2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdcnt1 = 0;
  int   a0cnt2 = 0;
  int   a1cnt2 = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  // Combinational sysid slave model
  assign rdata1 = (addr1 == SID_ADDR_TS) ? ts_data : id_data;
  assign rdata2 = (addr2 == SID_ADDR_TS) ? ts_data : id_data;

  cpu_ask2_sysid_checker u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .sid_address(addr1), .sid_read(rd1), .sid_readdata(rdata1),
    .busy(busy1), .done(done1), .match(match1), .id_ok(idok1), .ts_ok(tsok1),
    .id_value(idv1), .ts_value(tsv1), .retry_cnt(rc1)
  );

  cpu_ask2_sysid_checker #(.SETTLE_CYCLES(3), .AUTO_START(1'b0)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .sid_address(addr2), .sid_read(rd2), .sid_readdata(rdata2),
    .busy(busy2), .done(done2), .match(match2), .id_ok(idok2), .ts_ok(tsok2),
    .id_value(idv2), .ts_value(tsv2), .retry_cnt(rc2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Read-strobe activity counters
  always @(negedge clock) begin
    if (rd1 === 1'b1) rdcnt1++;
    if (rd2 === 1'b1 && addr2 === 1'b0) a0cnt2++;
    if (rd2 === 1'b1 && addr2 === 1'b1) a1cnt2++;
  end

  // Monitors: pop one expectation per done pulse
  always @(negedge clock) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("d1_done_cycle", cyc, e1.cyc);
        chk("d1_match", {31'd0, match1}, {31'd0, e1.m});
        chk("d1_id_ok", {31'd0, idok1}, {31'd0, e1.io});
        chk("d1_ts_ok", {31'd0, tsok1}, {31'd0, e1.to});
        chk("d1_id_value", idv1, e1.iv);
        chk("d1_ts_value", tsv1, e1.tv);
        chk("d1_retry_cnt", {29'd0, rc1}, {29'd0, e1.rc});
      end
    end
  end

  always @(negedge clock) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("d2_done_cycle", cyc, e2.cyc);
        chk("d2_match", {31'd0, match2}, {31'd0, e2.m});
        chk("d2_id_value", idv2, e2.iv);
        chk("d2_ts_value", tsv2, e2.tv);
      end
    end
  end

  task automatic push1(input int dly, input logic m, input logic io, input logic to,
                       input logic [31:0] iv, input logic [31:0] tv, input logic [2:0] rc);
    exp_t e;
    e.cyc = cyc + dly; e.m = m; e.io = io; e.to = to; e.iv = iv; e.tv = tv; e.rc = rc;
    q1.push_back(e);
  endtask

  task automatic wait_q1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL d1_timeout: got no done after %0d cycles expected done", budget);
      q1.delete();
    end
    @(negedge clock);
  endtask

  task automatic wait_q2(input int budget);
    int n = 0;
    while (q2.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL d2_timeout: got no done after %0d cycles expected done", budget);
      q2.delete();
    end
    @(negedge clock);
  endtask

  task automatic pulse1();
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
  endtask

  initial begin
    int r0, a0, a1;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_sid_read", {31'd0, rd1}, 32'd0);
    chk("rst_match", {31'd0, match1}, 32'd0);
    chk("rst_id_value", idv1, 32'd0);
    chk("rst_retry_cnt", {29'd0, rc1}, 32'd0);

    // Auto start after reset release, correct image
    push1(5, 1'b1, 1'b1, 1'b1, DEF_EXP_ID, DEF_EXP_TIMESTAMP, 3'd0);
    reset_n = 1'b1;
    wait_q1(40);
    chk("d2_idle_no_autostart", {31'd0, busy2}, 32'd0);

    // Wrong ID word
    id_data = 32'd22;
`ifdef SYSID_CHECKER_RETRY_EN
    push1(20, 1'b0, 1'b0, 1'b1, 32'd22, DEF_EXP_TIMESTAMP, 3'd3);
`else
    push1(5, 1'b0, 1'b0, 1'b1, 32'd22, DEF_EXP_TIMESTAMP, 3'd0);
`endif
    pulse1();
    wait_q1(40);

    // Correct image again; start pulsed at cycle 2 is ignored, results held
    id_data = DEF_EXP_ID;
    r0 = rdcnt1;
    push1(5, 1'b1, 1'b1, 1'b1, DEF_EXP_ID, DEF_EXP_TIMESTAMP, 3'd0);
    pulse1();
    @(negedge clock);
    chk("hold_id_value", idv1, 32'd22);
    chk("hold_match", {31'd0, match1}, 32'd0);
    pulse1();
    wait_q1(40);
    repeat (3) @(negedge clock);
    chk("read_cycles_one_check", rdcnt1 - r0, 32'd4);

`ifdef SYSID_CHECKER_RETRY_EN
    // Mismatch on first pass only
    id_data = 32'd22;
    push1(10, 1'b1, 1'b1, 1'b1, DEF_EXP_ID, DEF_EXP_TIMESTAMP, 3'd1);
    pulse1();
    repeat (5) @(negedge clock);
    id_data = DEF_EXP_ID;
    wait_q1(40);
`endif

    // Reset during TS_SETUP
    pulse1();
    repeat (2) @(negedge clock);
    chk("pre_rst_in_ts_setup", {30'd0, rd1, addr1}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
    chk("mid_rst_sid_read", {31'd0, rd1}, 32'd0);
    chk("mid_rst_match", {31'd0, match1}, 32'd0);
    chk("mid_rst_id_ok", {31'd0, idok1}, 32'd0);
    chk("mid_rst_id_value", idv1, 32'd0);
    chk("mid_rst_ts_value", tsv1, 32'd0);
    repeat (2) @(negedge clock);
    push1(5, 1'b1, 1'b1, 1'b1, DEF_EXP_ID, DEF_EXP_TIMESTAMP, 3'd0);
    reset_n = 1'b1;
    wait_q1(40);

    // SETTLE_CYCLES=3 instance, manual start
    a0 = a0cnt2;
    a1 = a1cnt2;
    e.cyc = cyc + 9; e.m = 1'b1; e.io = 1'b1; e.to = 1'b1;
    e.iv = DEF_EXP_ID; e.tv = DEF_EXP_TIMESTAMP; e.rc = 3'd0;
    q2.push_back(e);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    wait_q2(40);
    repeat (2) @(negedge clock);
    chk("d2_addr0_read_cycles", a0cnt2 - a0, 32'd4);
    chk("d2_addr1_read_cycles", a1cnt2 - a1, 32'd4);

    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_ask2_sysid_checker.md
# cpu_ASK2_sysid_checker

Boot-time sequencer that owns the read port of the system-ID slave and confirms the programmed FPGA image matches what the host software was built for. After reset, or on request, it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and publishes latched results plus a single pass/fail flag. It sits between the sysid slave and the CPU-side status logic, so firmware can gate boot on `match` instead of polling the slave itself.

## Interface
Parameters:
- EXP_ID, 32'd21, expected value at address 0
- EXP_TIMESTAMP, 32'd1526990575, expected value at address 1
- SETTLE_CYCLES, 1, cycles the address is held before capture (1..15)
- AUTO_START, 1, 1 = run one check automatically after reset release
- MAX_RETRY, 3, retries after mismatch (used only with retry enabled; 1..7)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse, requests a new check
- sid_address  out  1  address to sysid slave
- sid_read  out  1  read strobe to sysid slave
- sid_readdata  in  32  data from sysid slave (combinational slave, no waitrequest)
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of check
- match  out  1  1 = last check passed both words
- id_ok  out  1  ID word matched on last check
- ts_ok  out  1  timestamp word matched on last check
- id_value  out  32  ID word captured on last check
- ts_value  out  32  timestamp captured on last check
- retry_cnt  out  3  retries used on last check

## Operation
- Reset values: all outputs 0; state IDLE; settle counter 0.
- States: IDLE, ID_SETUP, ID_CAP, TS_SETUP, TS_CAP, EVAL.
- IDLE -> ID_SETUP on `start`, or on the first clock after reset release when AUTO_START=1. `busy` is 1 in every state except IDLE.
- ID_SETUP: sid_address=0, sid_read=1; hold SETTLE_CYCLES cycles using the counter, then go to ID_CAP.
- ID_CAP: sid_read=1; register sid_readdata into id_value; -> TS_SETUP.
- TS_SETUP/TS_CAP: same sequence with sid_address=1; capture into ts_value.
- EVAL: id_ok = (id_value==EXP_ID); ts_ok = (ts_value==EXP_TIMESTAMP); match = id_ok & ts_ok; pulse `done`; -> IDLE, or retry (see Configuration).
- sid_read=0 and sid_address=0 in IDLE and EVAL.
- `start` while busy: ignored and not queued. `start` in the same cycle as EVAL: ignored.
- id_ok, ts_ok, match, id_value and ts_value hold their values until the next EVAL. They are not cleared when a new check begins.
- Reset asserted mid-check: immediate return to the reset state. No done pulse. AUTO_START reruns the check after release.

## Timing
- With SETTLE_CYCLES=S, done pulses exactly 2(S+1)+1 cycles after the start-accept cycle. Default: 5 cycles.
- Capture happens S cycles after the address is first driven. The slave path must settle within S cycles.
- done is high for exactly 1 cycle. match/id_ok/ts_ok update in that same cycle.
- Back-to-back: the earliest accepted `start` is the cycle after done.

## Configuration
- SYSID_CHECKER_RETRY_EN defined:
  - On EVAL with match=0 and retry_cnt<MAX_RETRY: increment retry_cnt, no done pulse, go to ID_SETUP.
  - done is pulsed only on a pass or when retries are exhausted.
  - retry_cnt is cleared when a new start is accepted.
- Not defined: single pass; retry_cnt tied to 0; MAX_RETRY ignored.

## Structure
- Shared package cpu_ASK2_sysid_pkg holds:
  - the state enum
  - address constants SID_ADDR_ID=1'b0 and SID_ADDR_TS=1'b1
  - default expected-value constants, also used by the bench
- No sub-module. The FSM, settle counter and compare logic live in one module; the compare is two 32-bit equalities.

## Test plan
- Reset release, AUTO_START=1, slave returns 21/1526990575 -> done at cycle 5, match=1, id_ok=1, ts_ok=1, retry_cnt=0.
- Slave returns 22 at address 0 -> match=0, id_ok=0, ts_ok=1, id_value=22.
  - With RETRY_EN: done after 4 passes (20 cycles), retry_cnt=3.
- Mismatch on the first pass, correct from the second (RETRY_EN) -> done at cycle 10, match=1, retry_cnt=1.
- `start` pulsed at cycle 2 of a running check -> ignored; exactly one done; no extra sid_read cycles.
- reset_n dropped during TS_SETUP -> all outputs 0 at once, no done; with AUTO_START=1, a fresh check completes 5 cycles after release.
- SETTLE_CYCLES=3, manual `start` -> sid_address held 3 cycles per word, then 1 capture cycle per word; done 9 cycles after start.
